button_event: RTL and testbench
===============================

BUTTON_EVENT -- requirements
Module: button_event

Interface
REQ-001 SHALL have parameter clk_freq, default 100_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter long_ms, default 1000, hold time in ms before long_press fires.
REQ-003 SHALL have parameter repeat_ms, default 200, auto-repeat period in ms after long_press.
REQ-004 SHALL have port clk  input  1  system clock; one clock only.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port level  input  1  debounced, already-synchronous button level, 1 = pressed.
REQ-007 SHALL have port press  output  1  one-cycle pulse on press.
REQ-008 SHALL have port release  output  1  one-cycle pulse on release.
REQ-009 SHALL have port long_press  output  1  one-cycle pulse when hold reaches long_ms.
REQ-010 SHALL have port repeat  output  1  one-cycle pulse every repeat_ms while held after long_press.
REQ-011 SHALL have port held  output  1  registered level: 1 in PRESSED or LONG state.

Function
REQ-012 SHALL derive a 1 ms tick: divider counts 0..clk_freq/1000-1, one-cycle tick at terminal count, then wraps; width $clog2(clk_freq/1000)+1.
REQ-013 SHALL register level into prev each cycle; rise = level & ~prev; fall = ~level & prev.
REQ-014 SHALL implement FSM with states IDLE, PRESSED, LONG.
REQ-015 IDLE: on rise, assert press next cycle, clear hold counter and divider, go PRESSED.
REQ-016 PRESSED: hold counter increments per tick; when it reaches long_ms, pulse long_press, clear counter, go LONG.
REQ-017 LONG: counter increments per tick; when it reaches repeat_ms, pulse repeat, clear counter, stay LONG.
REQ-018 PRESSED or LONG: on fall, pulse release next cycle, go IDLE; release has priority over a coinciding long_press/repeat (that pulse is suppressed).
REQ-019 All outputs SHALL be registered; press/release latency exactly 1 clk after the level edge.
REQ-020 At most one of press, release, long_press, repeat SHALL be high in any cycle.
REQ-021 Hold counter width $clog2(max(long_ms,repeat_ms))+1; no wrap beyond terminal value.
REQ-022 long_ms = 0 or repeat_ms = 0 SHALL be rejected at elaboration ($error).

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, prev 0, counters 0, all outputs 0.
REQ-024 If level is 1 when reset_n releases, press SHALL pulse 1 cycle after the first post-reset edge of clk (prev reset 0 creates rise).
REQ-025 Reset mid-hold SHALL abort without emitting release.

Configuration
REQ-026 Macro BUTTON_EVENT_REPEAT_EN defined: LONG emits repeat per REQ-017.
REQ-027 Macro undefined: repeat tied 0, LONG state held until fall, counter stops in LONG.

Structure
REQ-028 Shared package button_pkg SHALL hold the state enum typedef (IDLE, PRESSED, LONG) and ms-per-second constant 1000.
REQ-029 The ms tick divider SHALL be sub-module ms_tick (params clk_freq; ports clk, reset_n, clr, tick).

Verification (clk_freq=1000 so tick every cycle, long_ms=5, repeat_ms=3, macro defined unless noted)
REQ-030 Short press: level 1 for 3 cycles then 0 -> press 1 cycle after rise, release 1 cycle after fall, no long_press.
REQ-031 Long hold: level 1 for 15 cycles -> press, long_press at hold count 5, repeat every 3 ticks thereafter, release after fall.
REQ-032 Fall in same cycle long_press would fire -> release only, long_press absent.
REQ-033 Macro undefined, 15-cycle hold -> long_press once, repeat never asserts.
REQ-034 reset_n pulsed low mid-LONG -> all outputs 0 asynchronously, no release; level still 1 after reset -> fresh press.
REQ-035 Every cycle: assert at most one event pulse high and held == (state != IDLE).

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and constants for the button event detector.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } state_t;

  localparam int MS_PER_SEC = 1000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_if.sv
// Bundle of the button level input and the event outputs of button_event.
interface button_event_if;
  logic level;
  logic press;
  logic release_pulse;
  logic long_press;
  logic repeat_pulse;
  logic held;

  modport master (
    output level,
    input  press, release_pulse, long_press, repeat_pulse, held
  );

  modport slave (
    input  level,
    output press, release_pulse, long_press, repeat_pulse, held
  );
endinterface

// File: rtl/ms_tick.sv
// Free-running 1 ms tick divider with synchronous clear.
module ms_tick
  import button_pkg::*;
#(
  parameter int clk_freq = 100_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic tick
);

  localparam int DIV = clk_freq / MS_PER_SEC;
  localparam int W   = $clog2(DIV) + 1;
  localparam logic [W-1:0] TERM = W'(DIV - 1);

  logic [W-1:0] cnt_r;

  assign tick = (cnt_r == TERM);

  // divider counter: wraps at terminal count, restarts on clr
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= {W{1'b0}};
    end else if (clr) begin
      cnt_r <= {W{1'b0}};
    end else if (tick) begin
      cnt_r <= {W{1'b0}};
    end else begin
      cnt_r <= cnt_r + W'(1);
    end
  end

endmodule

// File: rtl/button_event.sv
// Button event detector: press/release/long-press/auto-repeat pulses from a clean level.
// Auto-repeat is built only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event
  import button_pkg::*;
#(
  parameter int clk_freq  = 100_000_000,
  parameter int long_ms   = 1000,
  parameter int repeat_ms = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int CW = $clog2(max_int(long_ms, repeat_ms)) + 1;
  localparam logic [CW-1:0] LONG_CNT = CW'(long_ms);
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam logic [CW-1:0] REP_CNT = CW'(repeat_ms);
`endif

  if (long_ms == 0 || repeat_ms == 0) begin : g_bad_param
    $error("button_event: long_ms and repeat_ms must be non-zero");
  end

  state_t          state_r, state_s;
  logic            prev_r;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_inc_s;
  logic            rise_s, fall_s, tick_s, clr_s;
  logic            press_s, release_s, long_s, repeat_s;

  assign rise_s    = level & ~prev_r;
  assign fall_s    = ~level & prev_r;
  assign cnt_inc_s = cnt_r + CW'(1);

  ms_tick #(.clk_freq(clk_freq)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr_s),
    .tick    (tick_s)
  );

  // next-state, hold counter and event decode; release wins over long/repeat
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    clr_s     = 1'b0;
    press_s   = 1'b0;
    release_s = 1'b0;
    long_s    = 1'b0;
    repeat_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = {CW{1'b0}};
        if (rise_s) begin
          press_s = 1'b1;
          clr_s   = 1'b1;
          state_s = PRESSED;
        end else begin
          state_s = IDLE;
        end
      end
      PRESSED: begin
        if (fall_s) begin
          release_s = 1'b1;
          cnt_s     = {CW{1'b0}};
          state_s   = IDLE;
        end else if (tick_s) begin
          if (cnt_inc_s == LONG_CNT) begin
            long_s  = 1'b1;
            cnt_s   = {CW{1'b0}};
            state_s = LONG;
          end else begin
            cnt_s = cnt_inc_s;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      LONG: begin
        if (fall_s) begin
          release_s = 1'b1;
          cnt_s     = {CW{1'b0}};
          state_s   = IDLE;
`ifdef BUTTON_EVENT_REPEAT_EN
        end else if (tick_s) begin
          if (cnt_inc_s == REP_CNT) begin
            repeat_s = 1'b1;
            cnt_s    = {CW{1'b0}};
          end else begin
            cnt_s = cnt_inc_s;
          end
`endif
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CW{1'b0}};
      end
    endcase
  end

  // state, edge history, counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r       <= IDLE;
      prev_r        <= 1'b0;
      cnt_r         <= {CW{1'b0}};
      press         <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_r       <= state_s;
      prev_r        <= level;
      cnt_r         <= cnt_s;
      press         <= press_s;
      release_pulse <= release_s;
      long_press    <= long_s;
      repeat_pulse  <= repeat_s;
      held          <= (state_s != IDLE);
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event with a hold-time based reference model.
module tb_button_event;

  localparam int LONG_MS = 5;
  localparam int REP_MS  = 3;
`ifdef BUTTON_EVENT_REPEAT_EN
  localparam bit REP_EN = 1'b1;
`else
  localparam bit REP_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  button_event_if bus ();

  button_event #(
    .clk_freq  (1000),
    .long_ms   (LONG_MS),
    .repeat_ms (REP_MS)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .level         (bus.level),
    .press         (bus.press),
    .release_pulse (bus.release_pulse),
    .long_press    (bus.long_press),
    .repeat_pulse  (bus.repeat_pulse),
    .held          (bus.held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model: whether the button is considered down and for how many ms
  bit pr_m = 1'b0;
  int t_m  = 0;
  bit exp_press, exp_release, exp_long, exp_rep, exp_held;

  task automatic model_reset();
    pr_m = 1'b0; t_m = 0;
    exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0; exp_rep = 1'b0; exp_held = 1'b0;
  endtask

  task automatic model_update(input bit lv);
    exp_press = 1'b0; exp_release = 1'b0; exp_long = 1'b0; exp_rep = 1'b0;
    if (!pr_m && lv) begin
      exp_press = 1'b1; pr_m = 1'b1; t_m = 0;
    end else if (pr_m && !lv) begin
      exp_release = 1'b1; pr_m = 1'b0;
    end else if (pr_m) begin
      t_m++;
      if (t_m == LONG_MS) exp_long = 1'b1;
      else if (REP_EN && t_m > LONG_MS && ((t_m - LONG_MS) % REP_MS) == 0) exp_rep = 1'b1;
    end
    exp_held = pr_m;
  endtask

  task automatic check(input string tag);
    int ones;
    total++;
    assert (bus.press === exp_press) else begin
      bad++; $error("FAIL %s press: got %b want %b", tag, bus.press, exp_press);
    end
    total++;
    assert (bus.release_pulse === exp_release) else begin
      bad++; $error("FAIL %s release: got %b want %b", tag, bus.release_pulse, exp_release);
    end
    total++;
    assert (bus.long_press === exp_long) else begin
      bad++; $error("FAIL %s long_press: got %b want %b", tag, bus.long_press, exp_long);
    end
    total++;
    assert (bus.repeat_pulse === exp_rep) else begin
      bad++; $error("FAIL %s repeat: got %b want %b", tag, bus.repeat_pulse, exp_rep);
    end
    total++;
    assert (bus.held === exp_held) else begin
      bad++; $error("FAIL %s held: got %b want %b", tag, bus.held, exp_held);
    end
    ones = int'(bus.press) + int'(bus.release_pulse) + int'(bus.long_press) + int'(bus.repeat_pulse);
    total++;
    assert (ones <= 1) else begin
      bad++; $error("FAIL %s onehot: got %0d pulses want <=1", tag, ones);
    end
  endtask

  task automatic step(input bit lv, input string tag);
    bus.level = lv;
    @(posedge clk);
    model_update(lv);
    @(negedge clk);
    check(tag);
  endtask

  task automatic hold(input bit lv, input int n, input string tag);
    for (int i = 0; i < n; i++) step(lv, tag);
  endtask

  initial begin
    int run;
    bit lv;
    reset_n   = 1'b0;
    bus.level = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("reset");
    reset_n = 1'b1;
    hold(1'b0, 3, "idle");

    // short press
    hold(1'b1, 3, "short_hi");
    hold(1'b0, 3, "short_lo");

    // long hold with repeats
    hold(1'b1, 15, "long_hi");
    hold(1'b0, 3, "long_lo");

    // fall on the exact tick long_press would fire
    hold(1'b1, LONG_MS, "edge_hi");
    hold(1'b0, 3, "edge_lo");

    // asynchronous reset during LONG, level still high afterwards
    hold(1'b1, LONG_MS + 3, "rst_hi");
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("rst_async");
    @(negedge clk);
    check("rst_hold");
    reset_n = 1'b1;
    hold(1'b1, 4, "rst_repress");
    hold(1'b0, 2, "rst_lo");

    // randomized run lengths
    lv = 1'b0;
    for (int k = 0; k < 40; k++) begin
      lv  = ~lv;
      run = $urandom_range(1, 20);
      hold(lv, run, "rand");
    end
    hold(1'b0, 2, "final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
